// File: rtl/exu_hs.sv
// Single-issue execute unit: 1-cycle ALU ops and an iterative shift-add MUL (XLEN+1 cycles),
// with valid/ready on both sides; a held result stalls intake until out_ready drains it.
module exu_hs #(
  parameter int XLEN   = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            inv,
  input  logic [4:0]      rd,
  input  logic            r_wen,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_r_wen,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN) + 1;

  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_nxt;

  logic [XLEN-1:0] mcand, mplier, acc, acc_nxt, alu;
  logic [CW-1:0]   cnt;
  logic            mul_inv, mul_wen;
  logic [4:0]      mul_rd;
  logic            xfer, is_mul, last_step;
  logic [SHW-1:0]  shamt;

  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign xfer      = in_valid && in_ready && !flush;
  assign is_mul    = (op == 4'd10) && MUL_EN;
  assign busy      = (state == MUL);
  assign last_step = (cnt == CW'(XLEN - 1));
  assign acc_nxt   = acc + (mplier[0] ? mcand : '0);
  assign shamt     = src_b[SHW-1:0];

  always_comb begin
    alu = '0;
    case (op)
      4'd0: alu = src_a + src_b;
      4'd1: alu = src_a - src_b;
      4'd2: alu = src_a & src_b;
      4'd3: alu = src_a | src_b;
      4'd4: alu = src_a ^ src_b;
      4'd5: alu = src_a << shamt;
      4'd6: alu = src_a >> shamt;
      4'd7: alu = XLEN'($signed(src_a) >>> shamt);
      4'd8: alu = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      4'd9: alu = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      default: alu = '0;  // includes MUL when the multiplier is disabled
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (xfer && is_mul) state_nxt = MUL;
      MUL:  if (last_step) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
      out_r_wen  <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      mul_inv    <= 1'b0;
      mul_rd     <= '0;
      mul_wen    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (xfer) begin
        if (is_mul) begin
          mcand   <= src_a;
          mplier  <= src_b;
          acc     <= '0;
          cnt     <= '0;
          mul_inv <= inv;
          mul_rd  <= rd;
          mul_wen <= r_wen;
        end else begin
          out_valid  <= 1'b1;
          out_result <= alu ^ {{(XLEN-1){1'b0}}, inv};
          out_rd     <= rd;
          out_r_wen  <= r_wen;
        end
      end else if (state == MUL) begin
        // one multiplier bit per cycle, LSB first
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (last_step) begin
          out_valid  <= 1'b1;
          out_result <= acc_nxt ^ {{(XLEN-1){1'b0}}, mul_inv};
          out_rd     <= mul_rd;
          out_r_wen  <= mul_wen;
          cnt        <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_exu_hs.sv
// Bench for exu_hs: directed scenarios plus randomized traffic against a behavioural model.
module tb_exu_hs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = '0;
  logic [31:0] src_a = '0, src_b = '0;
  logic        inv = 1'b0;
  logic [4:0]  rd = '0;
  logic        r_wen = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_r_wen;
  logic        busy;

  logic        in_valid64 = 1'b0;
  logic        in_ready64;
  logic [3:0]  op64 = '0;
  logic [63:0] a64 = '0, b64 = '0;
  logic        inv64 = 1'b0;
  logic [4:0]  rd64 = '0;
  logic        wen64 = 1'b0;
  logic        out_valid64;
  logic        out_ready64 = 1'b1;
  logic [63:0] out_result64;
  logic [4:0]  out_rd64;
  logic        out_r_wen64;
  logic        busy64;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] r;
    logic [4:0]  rd;
    logic        w;
  } exp_t;

  always #5 clk = ~clk;

  exu_hs #(.XLEN(32), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src_a(src_a), .src_b(src_b), .inv(inv), .rd(rd), .r_wen(r_wen),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_r_wen(out_r_wen), .busy(busy)
  );

  exu_hs #(.XLEN(64), .MUL_EN(1'b0)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid64), .in_ready(in_ready64),
    .op(op64), .src_a(a64), .src_b(b64), .inv(inv64), .rd(rd64), .r_wen(wen64),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_result(out_result64),
    .out_rd(out_rd64), .out_r_wen(out_r_wen64), .busy(busy64)
  );

  // Behavioural reference for 32-bit ops, straight from the op table.
  function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic i);
    int unsigned     sh;
    int signed       sa, sb;
    longint unsigned prod;
    logic [31:0]     r;
    sh = b % 32;
    sa = a;
    sb = b;
    prod = longint'(a) * longint'(b);
    case (o)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << sh;
      4'd6: r = a >> sh;
      4'd7: r = sa >>> sh;
      4'd8: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd9: r = (a < b) ? 32'd1 : 32'd0;
      4'd10: r = prod[31:0];
      default: r = 32'd0;
    endcase
    return r ^ {31'd0, i};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_mul(input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; op = 4'd10; src_a = a; src_b = b; inv = 1'b0; rd = 5'd3; r_wen = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || out_result !== 32'd0 || out_rd !== 5'd0 || out_r_wen !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b r=%h rd=%h w=%b busy=%b want all 0",
               out_valid, out_result, out_rd, out_r_wen, busy);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    in_valid = 1'b1; op = 4'd0; src_a = 32'hFFFF_FFFF; src_b = 32'd1; inv = 1'b0;
    rd = 5'd5; r_wen = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd0 || out_rd !== 5'd5 || out_r_wen !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap: got v=%b r=%h rd=%0d w=%b want v=1 r=00000000 rd=5 w=1",
               out_valid, out_result, out_rd, out_r_wen);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got v=%b want 0", out_valid); end
  endtask

  task automatic test_slt_inv();
    in_valid = 1'b1; op = 4'd8; src_a = 32'h8000_0000; src_b = 32'd0; inv = 1'b1;
    rd = 5'd9; r_wen = 1'b0;
    tick();
    in_valid = 1'b0; inv = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd0 || out_r_wen !== 1'b0) begin
      errors++;
      $display("FAIL slt_inv: got v=%b r=%h w=%b want v=1 r=00000000 w=0", out_valid, out_result, out_r_wen);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; op = 4'd0; src_a = 32'd10; src_b = 32'd20; rd = 5'd1; r_wen = 1'b1;
    tick();
    src_a = 32'd100; src_b = 32'd200; rd = 5'd2;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd30 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_first: got v=%b r=%h rdy=%b want v=1 r=0000001e rdy=0", out_valid, out_result, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd30 || out_rd !== 5'd1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: got v=%b r=%h rd=%0d rdy=%b want v=1 r=0000001e rd=1 rdy=0",
               out_valid, out_result, out_rd, in_ready);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd300 || out_rd !== 5'd2) begin
      errors++;
      $display("FAIL bp_second: got v=%b r=%h rd=%0d want v=1 r=0000012c rd=2", out_valid, out_result, out_rd);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got v=%b want 0", out_valid); end
  endtask

  task automatic test_mul();
    int bad;
    bad = 0;
    start_mul(32'h0001_2345, 32'h0000_0100);
    for (int i = 0; i < 32; i++) begin
      if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mul_busy: got %0d bad cycles want 0", bad); end
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h0123_4500 || busy !== 1'b0 || out_rd !== 5'd3) begin
      errors++;
      $display("FAIL mul_result: got v=%b r=%h busy=%b rd=%0d want v=1 r=01234500 busy=0 rd=3",
               out_valid, out_result, busy, out_rd);
    end
    tick();
  endtask

  task automatic test_mul_random();
    logic [31:0] a, b;
    int cyc;
    for (int k = 0; k < 4; k++) begin
      a = $urandom; b = (k == 0) ? 32'hFFFF_FFFF : $urandom;
      start_mul(a, b);
      cyc = 1;
      while (out_valid !== 1'b1 && cyc < 100) begin tick(); cyc++; end
      checks++;
      if (cyc != 33) begin errors++; $display("FAIL mul_latency: got %0d want 33", cyc); end
      checks++;
      if (out_result !== model(4'd10, a, b, 1'b0)) begin
        errors++;
        $display("FAIL mul_rand: got %h want %h", out_result, model(4'd10, a, b, 1'b0));
      end
      tick();
    end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    int o;
    for (int n = 0; n < 80; n++) begin
      in_valid = $urandom_range(0, 1);
      o = $urandom_range(0, 14);
      if (o >= 10) o++;
      op = 4'(o);
      src_a = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      src_b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      inv = $urandom_range(0, 1);
      rd = 5'($urandom);
      r_wen = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (out_valid !== (q.size() != 0)) begin
        errors++; $display("FAIL rnd_valid: got %b want %b", out_valid, q.size() != 0);
      end
      checks++;
      if (in_ready !== (q.size() == 0 || out_ready)) begin
        errors++; $display("FAIL rnd_ready: got %b want %b", in_ready, q.size() == 0 || out_ready);
      end
      if (out_valid && out_ready && q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if (out_result !== e.r || out_rd !== e.rd || out_r_wen !== e.w) begin
          errors++;
          $display("FAIL rnd_data: got r=%h rd=%0d w=%b want r=%h rd=%0d w=%b",
                   out_result, out_rd, out_r_wen, e.r, e.rd, e.w);
        end
      end
      if (in_valid && in_ready) begin
        e.r = model(op, src_a, src_b, inv); e.rd = rd; e.w = r_wen;
        q.push_back(e);
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_result !== e.r) begin
        errors++; $display("FAIL rnd_last: got v=%b r=%h want v=1 r=%h", out_valid, out_result, e.r);
      end
    end
    tick();
  endtask

  task automatic test_flush_mul();
    int seen;
    start_mul(32'd7, 32'd9);
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    in_valid = 1'b1; op = 4'd0; src_a = 32'd1; src_b = 32'd1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_mul: got busy=%b rdy=%b v=%b want 0 1 0", busy, in_ready, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin if (out_valid !== 1'b0) seen++; tick(); end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL flush_stale: got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    in_valid = 1'b1; op = 4'd0; src_a = 32'd1; src_b = 32'd1; inv = 1'b0; rd = 5'd7; r_wen = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    start_mul(32'hDEAD_BEEF, 32'h1234_5678);
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== 32'd0 || out_rd !== 5'd0 || out_r_wen !== 1'b0 ||
        busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_mul: got v=%b r=%h rd=%0d w=%b busy=%b rdy=%b want 0 0 0 0 0 1",
               out_valid, out_result, out_rd, out_r_wen, busy, in_ready);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin if (out_valid !== 1'b0) seen++; tick(); end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rst_stale: got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_xlen64();
    in_valid64 = 1'b1; op64 = 4'd0; a64 = '1; b64 = 64'd1; inv64 = 1'b0; rd64 = 5'd9; wen64 = 1'b1;
    #1;
    checks++;
    if (in_ready64 !== 1'b1) begin errors++; $display("FAIL x64_ready: got %b want 1", in_ready64); end
    tick();
    checks++;
    if (out_valid64 !== 1'b1 || out_result64 !== 64'd0 || out_rd64 !== 5'd9 || out_r_wen64 !== 1'b1) begin
      errors++;
      $display("FAIL x64_add: got v=%b r=%h rd=%0d w=%b want v=1 r=0 rd=9 w=1",
               out_valid64, out_result64, out_rd64, out_r_wen64);
    end
    op64 = 4'd7; a64 = 64'h8000_0000_0000_0000; b64 = 64'd63;
    tick();
    checks++;
    if (out_result64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL x64_sra: got %h want ffffffffffffffff", out_result64);
    end
    op64 = 4'd10; a64 = 64'd3; b64 = 64'd5;
    tick();
    in_valid64 = 1'b0;
    checks++;
    if (out_valid64 !== 1'b1 || out_result64 !== 64'd0 || busy64 !== 1'b0) begin
      errors++;
      $display("FAIL x64_mul_off: got v=%b r=%h busy=%b want v=1 r=0 busy=0", out_valid64, out_result64, busy64);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_slt_inv();
    test_backpressure();
    test_mul();
    test_mul_random();
    test_random();
    test_flush_mul();
    test_reset_mid_mul();
    test_xlen64();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exu_hs.md
EXU_HS -- requirements
Module: exu_hs

Interface
- REQ-001 SHALL have parameter XLEN, default 32, datapath width (legal values 32 or 64).
- REQ-002 SHALL have parameter MUL_EN, default 1; 1 enables the iterative MUL op, 0 makes MUL return 0 in one cycle.
- REQ-003 SHALL have port clk, input, 1 bit; all state updates on its rising edge.
- REQ-004 SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low, clock is clk.
- REQ-005 SHALL have port flush, input, 1 bit; kills in-flight and held work.
- REQ-006 SHALL have port in_valid, input, 1 bit; upstream presents an op.
- REQ-007 SHALL have port in_ready, output, 1 bit; the block can accept an op this cycle.
- REQ-008 SHALL have port op, input, 4 bits; operation code.
- REQ-009 SHALL have ports src_a and src_b, input, XLEN bits each; operands.
- REQ-010 SHALL have port inv, input, 1 bit; invert bit 0 of the result.
- REQ-011 SHALL have port rd, input, 5 bits; destination register tag.
- REQ-012 SHALL have port r_wen, input, 1 bit; register write enable, passed through.
- REQ-013 SHALL have ports out_valid, output, 1 bit, and out_ready, input, 1 bit.
- REQ-014 SHALL have port out_result, output, XLEN bits.
- REQ-015 SHALL have ports out_rd, output, 5 bits, and out_r_wen, output, 1 bit.
- REQ-016 SHALL have port busy, output, 1 bit; high while in state MUL.

Function
- REQ-017 Op codes SHALL be:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR;
  - 5 SLL, 6 SRL, 7 SRA; shift amount is src_b[log2(XLEN)-1:0];
  - 8 SLT (signed), 9 SLTU (unsigned), giving 1 or 0;
  - 10 MUL, low XLEN bits of src_a*src_b;
  - 11-15 give a result of 0.
- REQ-018 Result SHALL be computed modulo 2^XLEN; the final result is result XOR {0…0, inv}.
- REQ-019 A transfer SHALL occur on a cycle where in_valid && in_ready && !flush.
- REQ-020 Transfer handshake SHALL be: in_ready = (state==IDLE) && (!out_valid || out_ready).
- REQ-021 The state machine SHALL have states IDLE and MUL.
- REQ-022 In IDLE, a non-MUL transfer (or MUL with MUL_EN=0) SHALL register result, rd and r_wen, and assert out_valid on the next edge; latency 1.
- REQ-023 In IDLE, a MUL transfer with MUL_EN=1 SHALL:
  - latch the operands, clear the accumulator and a counter, and enter MUL;
  - perform one shift-add step per cycle for XLEN cycles;
  - on the last step, load the output registers, set out_valid and return to IDLE, for a total latency of XLEN+1 cycles.
- REQ-024 The output registers SHALL hold their values, and out_valid SHALL stay high, until out_ready is sampled high; then out_valid clears unless a new transfer loads it on the same edge (back-to-back throughput 1 op/cycle for non-MUL ops).
- REQ-025 in_ready SHALL be 0 throughout state MUL.
- REQ-026 Flush SHALL take effect on the edge it is sampled high:
  - out_valid goes to 0 and the state goes to IDLE;
  - the counter and accumulator clear;
  - any input that cycle is dropped;
  - flush has priority over every other event.
- REQ-027 busy SHALL equal (state==MUL).
- REQ-028 out_result, out_rd and out_r_wen SHALL remain stable while out_valid=1 && out_ready=0.
- REQ-029 When out_valid=0, the output data ports SHALL hold their last values, and downstream ignores them.

Reset
- REQ-030 On rst_n=0 at a clock edge, the block SHALL reset as follows:
  - state goes to IDLE;
  - out_valid, out_result, out_rd, out_r_wen, busy, the counter and the accumulator go to 0;
  - in_ready reads 1 on the cycle after reset is released.
- REQ-031 Reset asserted mid-MUL SHALL abandon the operation, and no out_valid SHALL follow.

Verification
- REQ-032 ADD: src_a=0xFFFFFFFF, src_b=1, inv=0, out_ready=1 -> one cycle later out_valid=1, out_result=0x00000000, with out_rd and out_r_wen echoing the inputs.
- REQ-033 SLT with inv: src_a=0x80000000, src_b=0, op=8, inv=1 -> out_result=0.
- REQ-034 MUL with XLEN=32: src_a=0x00012345, src_b=0x00000100, held out_ready=1 ->
  - busy is high for 32 cycles and in_ready=0 throughout;
  - out_valid rises 33 cycles after the transfer, with out_result=0x01234500.
- REQ-035 Backpressure: out_ready=0 with two back-to-back ADD inputs ->
  - the first result is held stable and in_ready=0;
  - raising out_ready drains the first result, and the second is accepted on that same edge and appears on the next cycle.
- REQ-036 Flush at MUL step 10 -> next cycle busy=0, in_ready=1, and out_valid stays 0.
- REQ-037 Reset mid-MUL (rst_n low 1 cycle) -> all outputs 0 and no stale out_valid; repeat REQ-032 with XLEN=64 and expect 0x0000000000000000.
